ps2_scancode_ctrl: RTL

- Sequences raw bytes from the PS/2 keyboard receiver into decoded key events.
- Tracks E0 (extended) and F0 (break) prefixes and discards keyboard error/status codes.
- Aborts stalled prefix sequences on a timeout.
- Buffers events in a FIFO that the CPU-side peripheral interface drains with a valid/ready handshake.

---
 rtl/ps2_scancode_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_ctrl.sv
// rtl/ps2_scancode_ctrl.sv - PS/2 scancode sequencer with prefix decoding, timeout and event FIFO
//
// Decodes E0 (extended) and F0 (break) prefixed scancodes into {ext, brk, code}
// events. Status and error bytes are discarded. A stalled prefix is abandoned
// after TIMEOUT_CYCLES idle cycles. Events are queued in a first-word
// fall-through FIFO drained with evt_valid/evt_ready.
//
// Optional feature macro: KBD_TYPEMATIC_FILTER_EN (suppresses typematic make repeats).
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   rx_data, rx_valid    received byte and its one-cycle strobe
//   evt_code/ext/break   head event (zero while empty)
//   evt_valid, evt_ready head-event handshake
//   fifo_count           entries held
//   overflow             sticky drop flag, cleared by clear_overflow
module ps2_scancode_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  state_t          state;
  state_t          nxt_state;
  logic [TW-1:0]   tmo_cnt;
  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            dec_push;
  logic            dec_ext;
  logic            dec_brk;
  logic            suppress;
  logic            push_req;
  logic            pop;
  logic            full;
  logic            do_push;
  logic            drop;
  logic [9:0]      head;

  // Byte classification and next-state decode, used only when rx_valid=1.
  always_comb begin
    nxt_state = state;
    dec_push  = 1'b0;
    dec_ext   = 1'b0;
    dec_brk   = 1'b0;
    if (rx_data == 8'h00 || rx_data == 8'hFF) begin
      nxt_state = IDLE;
    end else if (rx_data == 8'hAA || rx_data == 8'hFA || rx_data == 8'hFC ||
                 rx_data == 8'hFE || rx_data == 8'hEE) begin
      nxt_state = state;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_data == 8'hE0)      nxt_state = GOT_E0;
          else if (rx_data == 8'hF0) nxt_state = GOT_F0;
          else if (rx_data != 8'hE1) dec_push  = 1'b1;
        end
        GOT_E0: begin
          if (rx_data == 8'hF0)      nxt_state = GOT_E0F0;
          else if (rx_data != 8'hE0) begin
            dec_push  = 1'b1;
            dec_ext   = 1'b1;
            nxt_state = IDLE;
          end
        end
        GOT_F0: begin
          if (rx_data == 8'hE0)      nxt_state = GOT_E0F0;
          else if (rx_data != 8'hF0) begin
            dec_push  = 1'b1;
            dec_brk   = 1'b1;
            nxt_state = IDLE;
          end
        end
        default: begin
          if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
            dec_push  = 1'b1;
            dec_ext   = 1'b1;
            dec_brk   = 1'b1;
            nxt_state = IDLE;
          end
        end
      endcase
    end
  end

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic       lm_valid;
  logic       lm_ext;
  logic [7:0] lm_code;
  logic       lm_match;

  assign lm_match = lm_valid && (lm_ext == dec_ext) && (lm_code == rx_data);
  assign suppress = !dec_brk && lm_match;

  // Last-make register tracks the key currently held so repeats can be dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lm_valid <= 1'b0;
      lm_ext   <= 1'b0;
      lm_code  <= 8'h00;
    end else if (rx_valid && dec_push) begin
      if (!dec_brk) begin
        if (!lm_match) begin
          lm_valid <= 1'b1;
          lm_ext   <= dec_ext;
          lm_code  <= rx_data;
        end
      end else if (lm_match) begin
        lm_valid <= 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign push_req = rx_valid && dec_push && !suppress;
  assign evt_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = evt_valid && evt_ready;
  // A full FIFO can still accept when the head leaves on the same edge.
  assign do_push   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  assign head       = mem[rd_ptr];
  assign evt_code   = evt_valid ? head[7:0] : 8'h00;
  assign evt_break  = evt_valid ? head[8]   : 1'b0;
  assign evt_ext    = evt_valid ? head[9]   : 1'b0;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= {dec_ext, dec_brk, rx_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // A byte on the timeout edge wins over the forced return to IDLE.
      if (rx_valid) begin
        state   <= nxt_state;
        tmo_cnt <= '0;
      end else if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TO_LAST) begin
        state   <= IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;

      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule
